pc_ctrl: RTL and testbench
==========================

Name: pc_ctrl

Overview:
- Fetch-stage PC sequencer.
- Owns the program counter and instruction-memory enable.
- Arbitrates redirect requests from trap logic (WB/CSR), the EX-stage branch unit and the ID-stage jump decoder against the hazard-unit stall.
- Generates pipeline-register flush strobes; implements reset, boot and halt sequencing for the front end of the 5-stage pipeline.

Parameters:
- ADDR_W, 32, PC / target width.
- RESET_PC, 32'h00000000, first fetch address after reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- stall_req  in  1  hazard unit: hold PC this cycle.
- jump_req  in  1  ID-stage jump taken.
- jump_target  in  ADDR_W  jump destination.
- branch_req  in  1  EX-stage branch taken.
- branch_target  in  ADDR_W  branch destination.
- trap_req  in  1  trap/interrupt redirect; also wakes from HALT.
- trap_vector  in  ADDR_W  trap handler address.
- halt_req  in  1  enter HALT (wfi/halt instruction retired).
- pc  out  ADDR_W  registered fetch address.
- inst_mem_en  out  1  registered instruction-memory enable.
- if_id_flush  out  1  combinational: squash IF/ID register.
- id_ex_flush  out  1  combinational: squash ID/EX register.
- align_err  out  1  registered one-cycle pulse: misaligned redirect target.
- halted  out  1  registered, high while in HALT.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, inst_mem_en=0, align_err=0, halted=0, state=S_RESET. All requests ignored; flushes 0.
- States: S_RESET, S_RUN, S_HALT (2-bit).
- S_RESET to S_RUN: first posedge with rst=1. inst_mem_en becomes 1; pc stays RESET_PC, so the first fetch is at RESET_PC. Unconditional.
- S_RUN per posedge, fixed priority trap > halt > branch > jump > stall > sequential:
  - trap_req: pc <= trap_vector; if_id_flush=id_ex_flush=1 in the request cycle.
  - halt_req: pc holds; inst_mem_en <= 0; halted <= 1; go S_HALT; if_id_flush=1.
  - branch_req: pc <= branch_target; if_id_flush=id_ex_flush=1.
  - jump_req: pc <= jump_target; if_id_flush=1, id_ex_flush=0.
  - stall_req only: pc holds; no flush.
  - none: pc <= pc + PC_STEP, modulo 2^ADDR_W (0xFFFFFFFC wraps to 0x00000000).
- Any redirect overrides a simultaneous stall: the redirect is taken and the stall is dropped for that cycle.
- Target alignment: a selected target with bits[1:0] != 0 is loaded with bits[1:0] forced to 00, and align_err pulses high on the following cycle. A target that is not selected never raises align_err.
- S_HALT:
  - pc, inst_mem_en=0 and halted=1 are held; only trap_req is honoured.
  - trap_req: pc <= trap_vector; inst_mem_en <= 1; halted <= 0; go S_RUN. No flush (pipeline already drained).
- Flush outputs are 0 outside S_RUN, except the halt-entry and trap cases above.
- Reset asserted mid-operation: immediate return to reset values regardless of state or pending requests.
- Latency: a request in cycle N gives the new pc value visible after posedge N+1; flushes are valid in cycle N.

Decomposition:
- defines.v additions:
  - `inst_addr_bus` (reuse existing).
  - `chip_enable` / `chip_disable` (reuse existing).
  - Active-low reset level constant `rst_n_enable` = 1'b0.
  - State encodings `pcs_reset` = 2'b00, `pcs_run` = 2'b01, `pcs_halt` = 2'b10.
  - `pc_step` = 4.
- Sub-module pc_next_mux: purely combinational priority select plus alignment. Outputs next_pc, redirect, misaligned and flush vector. pc_ctrl keeps the FSM and registers.

Test Plan:
- Reset release, no requests: pc=0x0 with inst_mem_en=1 in the first cycle, then 0x4, 0x8, 0xC on successive cycles; flushes stay 0.
- Sequential fetch at pc=0x10; stall_req high 2 cycles: pc holds 0x10 for 2 cycles, then 0x14; no flush.
- Same cycle, branch_req (target 0x200), jump_req (target 0x300) and stall_req: pc=0x200 next cycle; if_id_flush=id_ex_flush=1 in the request cycle.
- jump_req with target 0x103: pc=0x100, align_err pulses exactly one cycle, if_id_flush=1, id_ex_flush=0.
- halt_req at pc=0x40: halted=1 and inst_mem_en=0 next cycle; pc stays 0x40; branch_req is ignored. Then trap_req with vector 0x80: pc=0x80, inst_mem_en=1, halted=0.
- pc forced to 0xFFFFFFFC via trap_vector, then no requests: pc wraps to 0x00000000. Then rst pulsed low mid-stall: outputs return to reset values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_RUN   = 2'b01,
    S_HALT  = 2'b10
  } pc_state_e;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam int   PC_STEP_DEF  = 4;

  typedef struct packed {
    logic if_id;
    logic id_ex;
  } flush_t;

endpackage

// File: rtl/pc_ctrl_next_mux.sv
// Combinational next-PC select for the running pipeline: fixed redirect
// priority, target word alignment and pipeline-register flush vector.
module pc_ctrl_next_mux
  import pc_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              stall_req_i,
  input  logic              jump_req_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic              branch_req_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] trap_vector_i,
  input  logic              halt_req_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              redirect_o,
  output logic              misaligned_o,
  output logic              halt_sel_o,
  output flush_t            flush_o
);

  logic [ADDR_W-1:0] target;
  logic              redirect;

  always_comb begin
    target       = '0;
    redirect     = 1'b0;
    halt_sel_o   = 1'b0;
    flush_o      = '0;
    misaligned_o = 1'b0;
    next_pc_o    = pc_i + ADDR_W'(PC_STEP);

    if (trap_req_i) begin
      target   = trap_vector_i;
      redirect = 1'b1;
      flush_o  = '{if_id: 1'b1, id_ex: 1'b1};
    end else if (halt_req_i) begin
      next_pc_o  = pc_i;
      halt_sel_o = 1'b1;
      flush_o    = '{if_id: 1'b1, id_ex: 1'b0};
    end else if (branch_req_i) begin
      target   = branch_target_i;
      redirect = 1'b1;
      flush_o  = '{if_id: 1'b1, id_ex: 1'b1};
    end else if (jump_req_i) begin
      target   = jump_target_i;
      redirect = 1'b1;
      flush_o  = '{if_id: 1'b1, id_ex: 1'b0};
    end else if (stall_req_i) begin
      next_pc_o = pc_i;
    end

    // Only the winning target is aligned and reported.
    if (redirect) begin
      next_pc_o    = {target[ADDR_W-1:2], 2'b00};
      misaligned_o = |target[1:0];
    end

    redirect_o = redirect;
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage PC sequencer: reset/boot/halt FSM, PC and imem-enable registers,
// flush strobes driven from the next-PC mux while running.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = PC_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_req,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_req,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              trap_req,
  input  logic [ADDR_W-1:0] trap_vector,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc,
  output logic              inst_mem_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              align_err,
  output logic              halted
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              en_q, en_d;
  logic              align_q, align_d;
  logic              halted_q, halted_d;

  logic [ADDR_W-1:0] mux_next_pc;
  logic              mux_redirect;
  logic              mux_misaligned;
  logic              mux_halt_sel;
  flush_t            mux_flush;

  pc_ctrl_next_mux #(
    .ADDR_W (ADDR_W),
    .PC_STEP(PC_STEP)
  ) u_next_mux (
    .pc_i           (pc_q),
    .stall_req_i    (stall_req),
    .jump_req_i     (jump_req),
    .jump_target_i  (jump_target),
    .branch_req_i   (branch_req),
    .branch_target_i(branch_target),
    .trap_req_i     (trap_req),
    .trap_vector_i  (trap_vector),
    .halt_req_i     (halt_req),
    .next_pc_o      (mux_next_pc),
    .redirect_o     (mux_redirect),
    .misaligned_o   (mux_misaligned),
    .halt_sel_o     (mux_halt_sel),
    .flush_o        (mux_flush)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    en_d        = en_q;
    halted_d    = halted_q;
    align_d     = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;

    unique case (state_q)
      S_RESET: begin
        state_d = S_RUN;
        en_d    = CHIP_ENABLE;
      end
      S_RUN: begin
        pc_d        = mux_next_pc;
        align_d     = mux_redirect & mux_misaligned;
        if_id_flush = mux_flush.if_id;
        id_ex_flush = mux_flush.id_ex;
        if (mux_halt_sel) begin
          state_d  = S_HALT;
          en_d     = CHIP_DISABLE;
          halted_d = 1'b1;
        end
      end
      S_HALT: begin
        // Trap has top priority in the mux, so its aligned vector is next_pc.
        if (trap_req) begin
          state_d  = S_RUN;
          pc_d     = mux_next_pc;
          align_d  = mux_misaligned;
          en_d     = CHIP_ENABLE;
          halted_d = 1'b0;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_RESET;
      pc_q     <= RESET_PC;
      en_q     <= CHIP_DISABLE;
      align_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      en_q     <= en_d;
      align_q  <= align_d;
      halted_q <= halted_d;
    end
  end

  assign pc          = pc_q;
  assign inst_mem_en = en_q;
  assign align_err   = align_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus randomized traffic
// against a behavioural model of the fetch sequencer.
module tb_pc_ctrl;

  localparam int          W        = 32;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         stall_req = 1'b0, jump_req = 1'b0, branch_req = 1'b0;
  logic         trap_req = 1'b0, halt_req = 1'b0;
  logic [W-1:0] jump_target = '0, branch_target = '0, trap_vector = '0;
  logic [W-1:0] pc;
  logic         inst_mem_en, if_id_flush, id_ex_flush, align_err, halted;

  int checks = 0;
  int errors = 0;

  // behavioural model
  logic [31:0] m_pc;
  bit          m_en, m_halted, m_align, m_booted;

  pc_ctrl #(.ADDR_W(W), .RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req    (stall_req),
    .jump_req     (jump_req),
    .jump_target  (jump_target),
    .branch_req   (branch_req),
    .branch_target(branch_target),
    .trap_req     (trap_req),
    .trap_vector  (trap_vector),
    .halt_req     (halt_req),
    .pc           (pc),
    .inst_mem_en  (inst_mem_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .align_err    (align_err),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = RST_PC; m_en = 0; m_halted = 0; m_align = 0; m_booted = 0;
  endtask

  task automatic model_load(input logic [31:0] t);
    m_pc    = t & ~32'h3;
    m_align = (t % 4) != 0;
  endtask

  task automatic model_step();
    m_align = 0;
    if (!m_booted) begin
      m_booted = 1; m_en = 1;
    end else if (m_halted) begin
      if (trap_req) begin
        model_load(trap_vector); m_halted = 0; m_en = 1;
      end
    end else if (trap_req)   model_load(trap_vector);
    else if (halt_req) begin m_halted = 1; m_en = 0; end
    else if (branch_req)     model_load(branch_target);
    else if (jump_req)       model_load(jump_target);
    else if (!stall_req)     m_pc = m_pc + 32'd4;
  endtask

  function automatic logic [1:0] model_flush();
    if (!rst || !m_booted || m_halted) return 2'b00;
    if (trap_req)   return 2'b11;
    if (halt_req)   return 2'b10;
    if (branch_req) return 2'b11;
    if (jump_req)   return 2'b10;
    return 2'b00;
  endfunction

  task automatic drive(input logic s, input logic j, input logic b, input logic t,
                       input logic h, input logic [31:0] jt, input logic [31:0] bt,
                       input logic [31:0] tv);
    stall_req = s; jump_req = j; branch_req = b; trap_req = t; halt_req = h;
    jump_target = jt; branch_target = bt; trap_vector = tv;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1, 1, 1, 1, 1, 32'h300, 32'h200, 32'h80);
    #1;
    checks++;
    if ({pc, inst_mem_en, halted, align_err} !== {RST_PC, 3'b000}) begin
      errors++;
      $display("FAIL reset_regs got pc=%h en=%b halted=%b ae=%b want pc=%h en=0 halted=0 ae=0",
               pc, inst_mem_en, halted, align_err, RST_PC);
    end
    checks++;
    if ({if_id_flush, id_ex_flush} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flush got %b%b want 00", if_id_flush, id_ex_flush);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_seq();
    logic [31:0] exp_seq [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({if_id_flush, id_ex_flush} !== 2'b00) begin
        errors++;
        $display("FAIL seq_flush[%0d] got %b%b want 00", i, if_id_flush, id_ex_flush);
      end
      tick();
      checks++;
      if (pc !== exp_seq[i] || inst_mem_en !== 1'b1) begin
        errors++;
        $display("FAIL seq_pc[%0d] got pc=%h en=%b want pc=%h en=1", i, pc, inst_mem_en, exp_seq[i]);
      end
    end
  endtask

  task automatic test_stall();
    tick();
    checks++;
    if (pc !== 32'h10) begin
      errors++; $display("FAIL stall_pre got pc=%h want 00000010", pc);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if ({if_id_flush, id_ex_flush} !== 2'b00) begin
        errors++; $display("FAIL stall_flush[%0d] got %b%b want 00", i, if_id_flush, id_ex_flush);
      end
      tick();
      checks++;
      if (pc !== 32'h10) begin
        errors++; $display("FAIL stall_hold[%0d] got pc=%h want 00000010", i, pc);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (pc !== 32'h14) begin
      errors++; $display("FAIL stall_release got pc=%h want 00000014", pc);
    end
  endtask

  task automatic test_redirect_prio();
    drive(1, 1, 1, 0, 0, 32'h300, 32'h200, 32'h0);
    #1;
    checks++;
    if ({if_id_flush, id_ex_flush} !== 2'b11) begin
      errors++; $display("FAIL prio_flush got %b%b want 11", if_id_flush, id_ex_flush);
    end
    tick();
    checks++;
    if (pc !== 32'h200 || align_err !== 1'b0) begin
      errors++; $display("FAIL prio_pc got pc=%h ae=%b want pc=00000200 ae=0", pc, align_err);
    end
  endtask

  task automatic test_align();
    drive(0, 1, 0, 0, 0, 32'h103, 32'h0, 32'h0);
    #1;
    checks++;
    if ({if_id_flush, id_ex_flush} !== 2'b10) begin
      errors++; $display("FAIL align_flush got %b%b want 10", if_id_flush, id_ex_flush);
    end
    tick();
    checks++;
    if (pc !== 32'h100 || align_err !== 1'b1) begin
      errors++; $display("FAIL align_pulse got pc=%h ae=%b want pc=00000100 ae=1", pc, align_err);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (pc !== 32'h104 || align_err !== 1'b0) begin
      errors++; $display("FAIL align_clear got pc=%h ae=%b want pc=00000104 ae=0", pc, align_err);
    end
  endtask

  task automatic test_halt();
    drive(0, 1, 0, 0, 0, 32'h40, 32'h0, 32'h0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    #1;
    checks++;
    if ({if_id_flush, id_ex_flush} !== 2'b10 || pc !== 32'h40) begin
      errors++; $display("FAIL halt_entry_flush got %b%b pc=%h want 10 pc=00000040", if_id_flush, id_ex_flush, pc);
    end
    tick();
    checks++;
    if ({pc, inst_mem_en, halted} !== {32'h40, 2'b01}) begin
      errors++; $display("FAIL halt_state got pc=%h en=%b halted=%b want pc=00000040 en=0 halted=1", pc, inst_mem_en, halted);
    end
    drive(1, 1, 1, 0, 0, 32'h600, 32'h500, 32'h0);
    #1;
    checks++;
    if ({if_id_flush, id_ex_flush} !== 2'b00) begin
      errors++; $display("FAIL halt_ignore_flush got %b%b want 00", if_id_flush, id_ex_flush);
    end
    tick();
    checks++;
    if ({pc, inst_mem_en, halted, align_err} !== {32'h40, 3'b010}) begin
      errors++; $display("FAIL halt_ignore got pc=%h en=%b halted=%b ae=%b want pc=00000040 en=0 halted=1 ae=0", pc, inst_mem_en, halted, align_err);
    end
    drive(0, 0, 0, 1, 0, 0, 0, 32'h80);
    #1;
    checks++;
    if ({if_id_flush, id_ex_flush} !== 2'b00) begin
      errors++; $display("FAIL wake_flush got %b%b want 00", if_id_flush, id_ex_flush);
    end
    tick();
    checks++;
    if ({pc, inst_mem_en, halted} !== {32'h80, 2'b10}) begin
      errors++; $display("FAIL wake got pc=%h en=%b halted=%b want pc=00000080 en=1 halted=0", pc, inst_mem_en, halted);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_wrap_and_async_reset();
    drive(0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC);
    #1;
    checks++;
    if ({if_id_flush, id_ex_flush} !== 2'b11) begin
      errors++; $display("FAIL trap_flush got %b%b want 11", if_id_flush, id_ex_flush);
    end
    tick();
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL trap_pc got pc=%h want fffffffc", pc);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (pc !== 32'h0) begin
      errors++; $display("FAIL wrap got pc=%h want 00000000", pc);
    end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (pc !== 32'h4 || inst_mem_en !== 1'b1) begin
      errors++; $display("FAIL pre_reset got pc=%h en=%b want pc=00000004 en=1", pc, inst_mem_en);
    end
    @(posedge clk);
    model_step();
    #2;
    rst = 1'b0;
    trap_req = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({pc, inst_mem_en, halted, align_err} !== {RST_PC, 3'b000}) begin
      errors++; $display("FAIL async_reset got pc=%h en=%b halted=%b ae=%b want pc=%h en=0 halted=0 ae=0", pc, inst_mem_en, halted, align_err, RST_PC);
    end
    checks++;
    if ({if_id_flush, id_ex_flush} !== 2'b00) begin
      errors++; $display("FAIL async_reset_flush got %b%b want 00", if_id_flush, id_ex_flush);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    checks++;
    if (pc !== RST_PC || inst_mem_en !== 1'b1) begin
      errors++; $display("FAIL reboot got pc=%h en=%b want pc=%h en=1", pc, inst_mem_en, RST_PC);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] jt, bt, tv;
      jt = $urandom; bt = $urandom; tv = $urandom;
      if ($urandom_range(1, 0) == 0) jt[1:0] = 2'b00;
      if ($urandom_range(1, 0) == 0) bt[1:0] = 2'b00;
      if ($urandom_range(1, 0) == 0) tv[1:0] = 2'b00;
      drive($urandom_range(2, 0) == 0, $urandom_range(3, 0) == 0,
            $urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0,
            $urandom_range(15, 0) == 0, jt, bt, tv);
      #1;
      checks++;
      if ({if_id_flush, id_ex_flush} !== model_flush()) begin
        errors++; $display("FAIL rand_flush[%0d] got %b%b want %b", i, if_id_flush, id_ex_flush, model_flush());
      end
      tick();
      checks++;
      if ({pc, inst_mem_en, halted, align_err} !== {m_pc, m_en, m_halted, m_align}) begin
        errors++;
        $display("FAIL rand_regs[%0d] got pc=%h en=%b halted=%b ae=%b want pc=%h en=%b halted=%b ae=%b",
                 i, pc, inst_mem_en, halted, align_err, m_pc, m_en, m_halted, m_align);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_seq();
    test_stall();
    test_redirect_prio();
    test_align();
    test_halt();
    test_wrap_and_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
